ahb_mem_slave: RTL and testbench
================================

AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address bus width in bits.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning memory size in DATA_W words; must be a power of two.
REQ-004 SHALL have parameter WAIT_STATES, default 0, meaning data-phase stall cycles per accepted transfer; legal range 0..7.
REQ-005 SHALL have parameter BASE_ADDR, default 0, meaning byte base address of the window; aligned to DEPTH*DATA_W/8.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port hsel, input, 1 bit: slave select.
REQ-009 SHALL have port haddr, input, ADDR_W bits: byte address.
REQ-010 SHALL have port htrans, input, 2 bits: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-011 SHALL have port hwrite, input, 1 bit: 1 = write.
REQ-012 SHALL have port hsize, input, 3 bits: transfer size is 2^hsize bytes.
REQ-013 SHALL have port hwdata, input, DATA_W bits: write data, data phase.
REQ-014 SHALL have port hready, input, 1 bit: bus-level ready.
REQ-015 SHALL have port hreadyout, output, 1 bit: slave ready.
REQ-016 SHALL have port hresp, output, 1 bit: 0 = OKAY, 1 = ERROR.
REQ-017 SHALL have port hrdata, output, DATA_W bits: read data.

Function
REQ-018 A transfer SHALL be accepted in the cycle where hsel & htrans[1] & hready = 1; haddr, hwrite and hsize are latched into the data-phase register.
REQ-019 The FSM SHALL have states IDLE, WAIT, DATA, ERR1, ERR2.
REQ-020 On acceptance, the FSM SHALL enter WAIT when WAIT_STATES>0, otherwise DATA, or ERR1 on error.
REQ-021 WAIT SHALL hold hreadyout=0 for exactly WAIT_STATES cycles, counted by a 3-bit counter, then go to DATA.
REQ-022 DATA SHALL drive hreadyout=1 and hresp=0.
REQ-023 In DATA, a new acceptance in the same cycle SHALL give back-to-back pipelining; otherwise the FSM returns to IDLE.
REQ-024 IDLE, BUSY and unselected cycles SHALL give a zero-wait OKAY with hreadyout=1.
REQ-025 A write SHALL commit hwdata in the DATA cycle, using byte lanes derived from the latched hsize and addr[log2(DATA_W/8)-1:0].
REQ-026 Read data SHALL be valid on hrdata in the DATA cycle; hrdata SHALL be 0 outside DATA.
REQ-027 A read to the address written in the immediately preceding DATA cycle SHALL return the merged new bytes (write-to-read forwarding).
REQ-028 ERR1 SHALL drive hreadyout=0 and hresp=1; ERR2 SHALL drive hreadyout=1 and hresp=1; an erroring write SHALL not modify memory.
REQ-029 hsize > log2(DATA_W/8) SHALL produce an ERROR response.
REQ-030 An address misaligned to hsize SHALL produce an ERROR response.
REQ-031 A word index >= DEPTH SHALL wrap modulo DEPTH unless AHB_MEM_SLAVE_RANGE_ERR_EN is defined.

Reset
REQ-032 While rst=1, the block SHALL set the FSM to IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter 0, and clear the forwarding register.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer without a memory write; memory contents are not reset.

Configuration
REQ-034 With AHB_MEM_SLAVE_RANGE_ERR_EN defined, an address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8) SHALL give a two-cycle ERROR response.
REQ-035 Without AHB_MEM_SLAVE_RANGE_ERR_EN, address bits above the index SHALL be ignored and the address wraps.

Structure
REQ-036 Package ahb_pkg SHALL hold the htrans and hsize encodings, the FSM state enum and the AHB_DATA_WIDTH/AHB_ADDR_WIDTH constants.
REQ-037 The storage SHALL be a sub-module ahb_sram_array: DEPTH x DATA_W, byte-enable write, combinational read.

Verification
REQ-038 WAIT_STATES=0: NONSEQ write 0xDEADBEEF to 0x10 with hsize=2, then read 0x10 -> hreadyout stays 1 and hrdata=0xDEADBEEF in the second data phase (forwarded).
REQ-039 WAIT_STATES=3: single read -> hreadyout low for exactly 3 cycles, then high with hresp=0.
REQ-040 Byte write 0xAA to 0x13 over a word 0x11223344 -> read of 0x10 returns 0xAA223344.
REQ-041 hsize=2 at address 0x02 -> hreadyout 0/1 with hresp 1/1 over two cycles, and memory is unchanged.
REQ-042 With AHB_MEM_SLAVE_RANGE_ERR_EN and DEPTH=1024, access to 0x1000 -> ERROR; without the macro, the same access aliases to 0x0.
REQ-043 rst pulsed during WAIT -> next cycle shows hreadyout=1, hresp=0, and the pending write is absent.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings, FSM state set, default bus widths and a byte-lane helper
// used by ahb_mem_slave.
package ahb_pkg;

  localparam int AHB_DATA_WIDTH = 32;
  localparam int AHB_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  // Byte enables for a 2^size-byte transfer at lane offset; only called for size <= 3.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] offset);
    logic [15:0] m;
    m = (16'd1 << (4'd1 << size)) - 16'd1;
    m = m << offset;
    return m[7:0];
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// DEPTH x DATA_W storage for ahb_mem_slave: byte-enable synchronous write,
// combinational read on the same word index.
module ahb_sram_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DATA_W/8-1:0]      be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave with optional data-phase wait states and two-cycle ERROR.
// Define AHB_MEM_SLAVE_RANGE_ERR_EN to flag accesses outside the BASE_ADDR window instead of wrapping.
//
// state | meaning
// IDLE  | no data phase pending, zero-wait OKAY
// WAIT  | accepted transfer stalled, hreadyout low
// DATA  | data phase completes: write commits / read data valid
// ERR1  | first ERROR cycle, hreadyout low
// ERR2  | second ERROR cycle, hreadyout high
module ahb_mem_slave
  import ahb_pkg::*;
#(
  parameter int                DATA_W      = AHB_DATA_WIDTH,
  parameter int                ADDR_W      = AHB_ADDR_WIDTH,
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata
);

  localparam int NB    = DATA_W / 8;
  localparam int LB    = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [2:0] WS     = 3'(WAIT_STATES);
  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_WAIT = ST_WAIT;
  localparam logic [2:0] S_DATA = ST_DATA;
  localparam logic [2:0] S_ERR1 = ST_ERR1;
  localparam logic [2:0] S_ERR2 = ST_ERR2;

  logic [2:0]        state, state_nxt;
  logic [2:0]        wait_cnt;
  logic              slot_free, accept;
  logic              size_err, align_err, range_err, xfer_err;
  logic [2:0]        amask, a_off;
  logic [IDX_W-1:0]  d_idx;
  logic [2:0]        d_off, d_size;
  logic              d_write;
  logic              we;
  logic [7:0]        lanes;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] mem_rdata, rd_merged;
  logic              fwd_valid;
  logic [IDX_W-1:0]  fwd_idx;
  logic [NB-1:0]     fwd_be;
  logic [DATA_W-1:0] fwd_data;
  logic              unused_bits;

  assign slot_free = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept    = hsel & htrans[1] & hready & slot_free;

  assign size_err  = hsize > 3'(LB);
  assign amask     = 3'((4'd1 << hsize) - 4'd1);
  assign align_err = |(haddr[2:0] & amask);
  assign xfer_err  = size_err | align_err | range_err;

`ifdef AHB_MEM_SLAVE_RANGE_ERR_EN
  localparam int                AW1      = ADDR_W + 1;
  localparam logic [ADDR_W:0]   WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0]   WIN_HI   = WIN_LO + AW1'(DEPTH * NB);
  assign range_err   = ({1'b0, haddr} < WIN_LO) || ({1'b0, haddr} >= WIN_HI);
  assign unused_bits = ^{htrans[0], lanes};
`else
  // Bits above the word index are ignored so the window aliases through the address space.
  assign range_err   = 1'b0;
  assign unused_bits = ^{htrans[0], lanes, haddr[ADDR_W-1:LB+IDX_W]};
`endif

  always_comb begin
    a_off = '0;
    a_off[LB-1:0] = haddr[LB-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept) begin
          if (xfer_err)        state_nxt = S_ERR1;
          else if (WS != 3'd0) state_nxt = S_WAIT;
          else                 state_nxt = S_DATA;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT:  if (wait_cnt <= 3'd1) state_nxt = S_DATA;
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      fwd_valid <= 1'b0;
      fwd_idx   <= '0;
      fwd_be    <= '0;
      fwd_data  <= '0;
    end else begin
      state <= state_nxt;
      if (accept && !xfer_err)
        wait_cnt <= WS;
      else if (state == S_WAIT && wait_cnt != 3'd0)
        wait_cnt <= wait_cnt - 3'd1;
      if (state == S_DATA) begin
        fwd_valid <= d_write;
        fwd_idx   <= d_idx;
        fwd_be    <= be;
        fwd_data  <= hwdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      d_idx   <= haddr[LB +: IDX_W];
      d_off   <= a_off;
      d_size  <= hsize;
      d_write <= hwrite;
    end
  end

  assign lanes = lane_mask(d_size, d_off);
  assign be    = lanes[NB-1:0];
  assign we    = (state == S_DATA) & d_write & ~rst;

  ahb_sram_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk  (clk),
    .we   (we),
    .be   (be),
    .addr (d_idx),
    .wdata(hwdata),
    .rdata(mem_rdata)
  );

  // Overlay bytes from the last committed write so back-to-back reads see them.
  always_comb begin
    rd_merged = mem_rdata;
    for (int b = 0; b < NB; b++) begin
      if (fwd_valid && fwd_idx == d_idx && fwd_be[b])
        rd_merged[8*b +: 8] = fwd_data[8*b +: 8];
    end
  end

  assign hreadyout = rst | !((state == S_WAIT) || (state == S_ERR1));
  assign hresp     = ~rst & ((state == S_ERR1) || (state == S_ERR2));
  assign hrdata    = (!rst && state == S_DATA && !d_write) ? rd_merged : '0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: instance 0 has no wait states, instance 1 has three; both are
// compared every cycle against a transfer-level model, plus literal expectations per scenario.
module tb_ahb_mem_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [31:0] hwdata [2];
  logic        rdy    [2];
  logic        resp   [2];
  logic [31:0] rdata  [2];

  ahb_mem_slave #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]), .hwdata(hwdata[0]), .hready(rdy[0]),
    .hreadyout(rdy[0]), .hresp(resp[0]), .hrdata(rdata[0])
  );

  ahb_mem_slave #(.WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]), .hwdata(hwdata[1]), .hready(rdy[1]),
    .hreadyout(rdy[1]), .hresp(resp[1]), .hrdata(rdata[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- transfer-level model ----------------
  typedef struct packed {
    logic [1:0]  kind;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
  } ent_t;

  localparam logic [1:0] K_WAIT = 2'd0, K_DATA = 2'd1, K_E1 = 2'd2, K_E2 = 2'd3;
  localparam int WS_OF [2] = '{0, 3};

  ent_t        ring [2][16];
  int          head [2];
  int          cnt_q [2];
  logic [7:0]  mm [2][4096];
  logic [31:0] last_rd [2];
  int          low_run [2];
  int          last_low [2];
  int          low_total [2];
  logic [3:0]  err_obs [2];

  task automatic push(input int d, input ent_t e);
    ring[d][(head[d] + cnt_q[d]) % 16] = e;
    cnt_q[d]++;
  endtask

  function automatic logic [31:0] mword(input int d, input logic [31:0] a);
    logic [11:0] b;
    b = a[11:0] & 12'hFFC;
    return {mm[d][b+3], mm[d][b+2], mm[d][b+1], mm[d][b]};
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic [2:0] s);
    if (s > 3'd2) return 1'b1;
    if ((a % (32'd1 << s)) != 0) return 1'b1;
`ifdef AHB_MEM_SLAVE_RANGE_ERR_EN
    if (a >= 32'd4096) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_step(input int d);
    ent_t        e;
    bit          have, crd;
    logic        er, ep;
    logic [31:0] ed, a;
    ent_t        n;
    e = '0;
    have = cnt_q[d] > 0;
    if (have) begin
      e = ring[d][head[d]];
      head[d] = (head[d] + 1) % 16;
      cnt_q[d]--;
    end
    er = 1'b1; ep = 1'b0; ed = '0; crd = 1'b1;
    if (rst[d]) begin
      cnt_q[d] = 0;
    end else if (have) begin
      case (e.kind)
        K_WAIT: er = 1'b0;
        K_DATA: begin
          if (e.wr) begin
            crd = 1'b0;
            for (int i = 0; i < (1 << e.size); i++) begin
              a = e.addr + 32'(i);
              mm[d][a[11:0]] = hwdata[d][8*a[1:0] +: 8];
            end
          end else begin
            ed = mword(d, e.addr);
            last_rd[d] = rdata[d];
          end
        end
        K_E1: begin er = 1'b0; ep = 1'b1; err_obs[d][3:2] = {rdy[d], resp[d]}; end
        default: begin ep = 1'b1; err_obs[d][1:0] = {rdy[d], resp[d]}; end
      endcase
    end
    chk($sformatf("dut%0d hreadyout", d), 32'(rdy[d]), 32'(er));
    chk($sformatf("dut%0d hresp", d), 32'(resp[d]), 32'(ep));
    if (crd) chk($sformatf("dut%0d hrdata", d), rdata[d], ed);
    if (rdy[d] === 1'b0) begin
      low_run[d]++;
      low_total[d]++;
    end else if (low_run[d] != 0) begin
      last_low[d] = low_run[d];
      low_run[d] = 0;
    end
    if (!rst[d] && er && hsel[d] && htrans[d][1]) begin
      n.wr = hwrite[d]; n.addr = haddr[d]; n.size = hsize[d];
      if (model_err(haddr[d], hsize[d])) begin
        n.kind = K_E1; push(d, n);
        n.kind = K_E2; push(d, n);
      end else begin
        n.kind = K_WAIT;
        for (int i = 0; i < WS_OF[d]; i++) push(d, n);
        n.kind = K_DATA; push(d, n);
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } item_t;

  item_t seq [$];

  function automatic item_t mk(input logic sel, input logic [1:0] tr, input logic wr,
                               input logic [31:0] a, input logic [2:0] s, input logic [31:0] wd);
    item_t it;
    it.sel = sel; it.trans = tr; it.wr = wr; it.addr = a; it.size = s; it.wdata = wd;
    return it;
  endfunction

  function automatic item_t mk_w(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] s);
    return mk(1'b1, 2'd2, 1'b1, a, s, wd);
  endfunction

  function automatic item_t mk_r(input logic [31:0] a, input logic [2:0] s);
    return mk(1'b1, 2'd2, 1'b0, a, s, 32'h0);
  endfunction

  // Drives queued items pipelined, holding each address phase until the slave is ready.
  task automatic play(input int d);
    item_t it;
    bit    done, smp;
    while (seq.size() > 0) begin
      it = seq.pop_front();
      hsel[d] = it.sel; htrans[d] = it.trans; hwrite[d] = it.wr;
      haddr[d] = it.addr; hsize[d] = it.size;
      done = 1'b0;
      for (int g = 0; g < 40 && !done; g++) begin
        @(negedge clk);
        smp = rdy[d];
        @(posedge clk); #1;
        if (!(it.sel && it.trans[1])) done = 1'b1;
        else if (smp) begin
          hwdata[d] = it.wdata;
          done = 1'b1;
        end
      end
      if (!done) begin
        n_checks++;
        $display("FAIL dut%0d drv_timeout: addr %h never accepted", d, it.addr);
      end
    end
    hsel[d] = 1'b0; htrans[d] = 2'd0; hwrite[d] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = 2'd0;
      hwrite[d] = 1'b0; hsize[d] = 3'd2; hwdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset dut%0d hreadyout", d), 32'(rdy[d]), 32'd1);
      chk($sformatf("reset dut%0d hresp", d), 32'(resp[d]), 32'd0);
      chk($sformatf("reset dut%0d hrdata", d), rdata[d], 32'h0);
    end
    @(posedge clk); #1;

    // write then back-to-back read, no stall
    low_total[0] = 0;
    seq = '{mk_w(32'h10, 32'hDEADBEEF, 3'd2), mk_r(32'h10, 3'd2)};
    play(0);
    chk("fwd read data", last_rd[0], 32'hDEADBEEF);
    chk("fwd no stall", 32'(low_total[0]), 32'd0);

    // byte merge into existing word
    seq = '{mk_w(32'h10, 32'h11223344, 3'd2), mk_w(32'h13, 32'hAA000000, 3'd0), mk_r(32'h10, 3'd2)};
    play(0);
    chk("byte merge", last_rd[0], 32'hAA223344);

    // halfword in upper lanes
    seq = '{mk_w(32'h14, 32'h0, 3'd2), mk_w(32'h16, 32'h5A5A0000, 3'd1), mk_r(32'h16, 3'd1)};
    play(0);
    chk("halfword merge", last_rd[0], 32'h5A5A0000);

    // misaligned word write errors and leaves memory alone
    seq = '{mk_w(32'h0, 32'hCAFEBABE, 3'd2), mk_w(32'h2, 32'hFFFFFFFF, 3'd2), mk_r(32'h0, 3'd2)};
    play(0);
    chk("misaligned no write", last_rd[0], 32'hCAFEBABE);
    chk("misaligned err pair", 32'(err_obs[0]), 32'h7);

    // oversize and misaligned-halfword reads error
    err_obs[0] = 4'h0;
    seq = '{mk_r(32'h0, 3'd3), mk_r(32'h1, 3'd1)};
    play(0);
    chk("oversize err pair", 32'(err_obs[0]), 32'h7);

    // BUSY and unselected cycles are ignored
    seq = '{mk(1'b1, 2'd1, 1'b1, 32'h0, 3'd2, 32'h11111111),
            mk(1'b0, 2'd2, 1'b1, 32'h0, 3'd2, 32'h22222222),
            mk_r(32'h0, 3'd2)};
    play(0);
    chk("busy/unsel ignored", last_rd[0], 32'hCAFEBABE);

    // window aliasing / range error
    seq = '{mk_w(32'h1000, 32'h0BADF00D, 3'd2), mk_r(32'h0, 3'd2)};
    play(0);
`ifdef AHB_MEM_SLAVE_RANGE_ERR_EN
    chk("out of range", last_rd[0], 32'hCAFEBABE);
`else
    chk("alias to 0x0", last_rd[0], 32'h0BADF00D);
`endif

    // three wait states per transfer
    seq = '{mk_w(32'h8, 32'h13572468, 3'd2), mk_r(32'h8, 3'd2)};
    play(1);
    chk("ws3 read data", last_rd[1], 32'h13572468);
    chk("ws3 low cycles", 32'(last_low[1]), 32'd3);

    // reset during WAIT aborts the pending write
    seq = '{mk_w(32'h40, 32'h12345678, 3'd2)};
    play(1);
    hsel[1] = 1'b1; htrans[1] = 2'd2; hwrite[1] = 1'b1; haddr[1] = 32'h40; hsize[1] = 3'd2;
    @(posedge clk); #1;
    hsel[1] = 1'b0; htrans[1] = 2'd0; hwrite[1] = 1'b0; hwdata[1] = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    @(negedge clk);
    chk("post-reset hreadyout", 32'(rdy[1]), 32'd1);
    chk("post-reset hresp", 32'(resp[1]), 32'd0);
    @(posedge clk); #1;
    seq = '{mk_r(32'h40, 3'd2)};
    play(1);
    chk("aborted write absent", last_rd[1], 32'h12345678);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
